// File: rtl/if_id_fetch_stage.sv
// Fetch stage and IF/ID pipeline register with boot bubble, stall watchdog and
// optional stall/flush event counters (enabled by defining PERF_COUNTERS_EN).
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PCoff,
  input  logic        IFID_writeOff,
  input  logic        flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Jump_Target,
  input  logic [31:0] JR_Target,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IMem_Addr,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [1:0]  Fetch_State,
  output logic        Stall_Timeout,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);

  localparam logic [1:0]  ST_BOOT  = 2'b00;
  localparam logic [1:0]  ST_RUN   = 2'b01;
  localparam logic [1:0]  ST_STALL = 2'b10;
  localparam logic [1:0]  ST_FLUSH = 2'b11;
  localparam logic [16:0] MAX_STALL_C = {1'b0, 16'(MAX_STALL)};

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  logic        in_boot_s, stall_s, stall_act_s, flush_act_s;
  logic [31:0] pc_plus4_s, redirect_s;
  logic [16:0] wd_inc_s;

  assign in_boot_s   = (state_q == ST_BOOT);
  assign stall_s     = PCoff | IFID_writeOff;
  assign stall_act_s = ~in_boot_s & stall_s;
  // A flush coinciding with any stall is dropped; the hazard unit re-issues it.
  assign flush_act_s = ~in_boot_s & flush & ~stall_s;
  assign pc_plus4_s  = pc_q + 32'd4;
  assign wd_inc_s    = {1'b0, wd_cnt_q} + 17'd1;

  always_comb begin
    case (PCSrc)
      2'b00:   redirect_s = pc_plus4_s;
      2'b01:   redirect_s = Branch_Target;
      2'b10:   redirect_s = Jump_Target;
      2'b11:   redirect_s = JR_Target;
      default: redirect_s = pc_plus4_s;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_valid_d = ifid_valid_q;
    if (in_boot_s) begin
      state_d = ST_RUN;
    end else begin
      if (stall_s)    state_d = ST_STALL;
      else if (flush) state_d = ST_FLUSH;
      else            state_d = ST_RUN;

      if (PCoff)            pc_d = pc_q;
      else if (flush_act_s) pc_d = redirect_s;
      else                  pc_d = pc_plus4_s;

      if (IFID_writeOff) begin
        ifid_instr_d = ifid_instr_q;
      end else if (flush_act_s) begin
        ifid_instr_d = NOP_INSTR;
        ifid_pcp4_d  = 32'h0000_0000;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_instr_d = IMem_Data;
        ifid_pcp4_d  = pc_plus4_s;
        ifid_valid_d = 1'b1;
      end
    end
  end

  // Watchdog: counts consecutive stall cycles, saturating at the limit.
  always_comb begin
    wd_cnt_d  = 16'd0;
    timeout_d = timeout_q;
    if (stall_act_s) begin
      wd_cnt_d  = (wd_inc_s > MAX_STALL_C) ? MAX_STALL_C[15:0] : wd_inc_s[15:0];
      timeout_d = timeout_q | (wd_inc_s >= MAX_STALL_C);
    end else begin
      wd_cnt_d  = 16'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pcp4_q  <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      wd_cnt_q     <= 16'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_act_s) stall_cnt_q <= stall_cnt_q + 32'd1;
      else             stall_cnt_q <= stall_cnt_q;
      if (flush_act_s) flush_cnt_q <= flush_cnt_q + 32'd1;
      else             flush_cnt_q <= flush_cnt_q;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`else
  assign Stall_Count = 32'h0000_0000;
  assign Flush_Count = 32'h0000_0000;
`endif

  assign IMem_Addr        = pc_q;
  assign PC               = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pcp4_q;
  assign IFID_Valid       = ifid_valid_q;
  assign Fetch_State      = state_q;
  assign Stall_Timeout    = timeout_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: boot, sequential fetch, stalls, watchdog,
// flush redirects, PC wrap and asynchronous reset mid-stall.
module tb_if_id_fetch_stage;

`ifdef PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] TAG = 32'hA5A5_5A5A;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        PCoff, IFID_writeOff, flush;
  logic [1:0]  PCSrc;
  logic [31:0] Branch_Target, Jump_Target, JR_Target, IMem_Data, IMem_Addr;
  logic [31:0] PC, IFID_Instruction, IFID_PCPlus4, Stall_Count, Flush_Count;
  logic        IFID_Valid, Stall_Timeout;
  logic [1:0]  Fetch_State;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_pc;

  always #5 Clk = ~Clk;

  // Instruction memory: each word is its own address XOR a fixed tag.
  assign IMem_Data = IMem_Addr ^ TAG;

  if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP), .MAX_STALL(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PCoff(PCoff), .IFID_writeOff(IFID_writeOff),
    .flush(flush), .PCSrc(PCSrc), .Branch_Target(Branch_Target), .Jump_Target(Jump_Target),
    .JR_Target(JR_Target), .IMem_Data(IMem_Data), .IMem_Addr(IMem_Addr), .PC(PC),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .Fetch_State(Fetch_State), .Stall_Timeout(Stall_Timeout), .Stall_Count(Stall_Count),
    .Flush_Count(Flush_Count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pcp4,
                          input logic valid);
    chk({tag, "_instr"}, IFID_Instruction, instr);
    chk({tag, "_pcp4"}, IFID_PCPlus4, pcp4);
    chk({tag, "_valid"}, {31'd0, IFID_Valid}, {31'd0, valid});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, PC, 32'h0000_0000);
    chk({tag, "_addr"}, IMem_Addr, 32'h0000_0000);
    chk_ifid(tag, NOP, 32'h0000_0000, 1'b0);
    chk({tag, "_state"}, {30'd0, Fetch_State}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, Stall_Timeout}, 32'd0);
    chk({tag, "_scnt"}, Stall_Count, 32'd0);
    chk({tag, "_fcnt"}, Flush_Count, 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0; PCoff = 1'b0; IFID_writeOff = 1'b0; flush = 1'b0; PCSrc = 2'b00;
    Branch_Target = 32'h0000_0200; Jump_Target = 32'h0000_0100; JR_Target = 32'h0000_0300;
    #12;
    chk_reset("rst");
    Reset_n = 1'b1;

    // Boot bubble
    tick();
    chk("boot_state", {30'd0, Fetch_State}, 32'd1);
    chk("boot_pc", PC, 32'h0000_0000);
    chk("boot_valid", {31'd0, IFID_Valid}, 32'd0);

    // Sequential fetch up to PC=0x40
    exp_pc = 32'h0000_0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      chk("seq_pc", PC, exp_pc);
      chk_ifid("seq", (exp_pc - 32'd4) ^ TAG, exp_pc, 1'b1);
    end

    // Full stall for 3 cycles
    PCoff = 1'b1; IFID_writeOff = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", PC, 32'h0000_0040);
      chk_ifid("stall", 32'h0000_003C ^ TAG, 32'h0000_0040, 1'b1);
      chk("stall_state", {30'd0, Fetch_State}, 32'd2);
      chk("stall_tmo", {31'd0, Stall_Timeout}, 32'd0);
    end
    chk("stall_scnt3", Stall_Count, PERF ? 32'd3 : 32'd0);

    // Fourth stall cycle trips the watchdog
    tick();
    chk("wd_tmo", {31'd0, Stall_Timeout}, 32'd1);
    PCoff = 1'b0; IFID_writeOff = 1'b0;
    tick();
    chk("wd_sticky", {31'd0, Stall_Timeout}, 32'd1);
    chk("resume_pc", PC, 32'h0000_0044);
    chk_ifid("resume", 32'h0000_0040 ^ TAG, 32'h0000_0044, 1'b1);
    chk("resume_state", {30'd0, Fetch_State}, 32'd1);
    chk("resume_scnt", Stall_Count, PERF ? 32'd4 : 32'd0);

    // PCoff alone: PC held, IF/ID loads
    PCoff = 1'b1;
    tick();
    chk("pcoff_pc", PC, 32'h0000_0044);
    chk_ifid("pcoff", 32'h0000_0044 ^ TAG, 32'h0000_0048, 1'b1);
    chk("pcoff_state", {30'd0, Fetch_State}, 32'd2);

    // IFID_writeOff alone: PC advances, IF/ID held
    PCoff = 1'b0; IFID_writeOff = 1'b1;
    tick();
    chk("wroff_pc", PC, 32'h0000_0048);
    chk_ifid("wroff", 32'h0000_0044 ^ TAG, 32'h0000_0048, 1'b1);
    chk("wroff_scnt", Stall_Count, PERF ? 32'd6 : 32'd0);

    // Jump redirect
    IFID_writeOff = 1'b0; flush = 1'b1; PCSrc = 2'b10;
    tick();
    chk("jmp_pc", PC, 32'h0000_0100);
    chk_ifid("jmp", NOP, 32'h0000_0000, 1'b0);
    chk("jmp_state", {30'd0, Fetch_State}, 32'd3);
    chk("jmp_fcnt", Flush_Count, PERF ? 32'd1 : 32'd0);

    // Stall and flush together: stall wins
    PCoff = 1'b1; IFID_writeOff = 1'b1; PCSrc = 2'b01;
    tick();
    chk("sf_pc", PC, 32'h0000_0100);
    chk_ifid("sf", NOP, 32'h0000_0000, 1'b0);
    chk("sf_state", {30'd0, Fetch_State}, 32'd2);
    chk("sf_fcnt", Flush_Count, PERF ? 32'd1 : 32'd0);
    chk("sf_scnt", Stall_Count, PERF ? 32'd7 : 32'd0);

    // Remaining redirect sources
    PCoff = 1'b0; IFID_writeOff = 1'b0; PCSrc = 2'b11;
    tick();
    chk("jr_pc", PC, 32'h0000_0300);
    PCSrc = 2'b01;
    tick();
    chk("br_pc", PC, 32'h0000_0200);
    PCSrc = 2'b00;
    tick();
    chk("p4_pc", PC, 32'h0000_0204);
    chk_ifid("p4", NOP, 32'h0000_0000, 1'b0);
    chk("p4_fcnt", Flush_Count, PERF ? 32'd4 : 32'd0);
    flush = 1'b0;
    tick();
    chk("post_pc", PC, 32'h0000_0208);
    chk_ifid("post", 32'h0000_0204 ^ TAG, 32'h0000_0208, 1'b1);
    chk("post_state", {30'd0, Fetch_State}, 32'd1);

    // PC wrap at top of address space
    flush = 1'b1; PCSrc = 2'b11; JR_Target = 32'hFFFF_FFFC;
    tick();
    chk("top_pc", PC, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick();
    chk("wrap_pc", PC, 32'h0000_0000);
    chk_ifid("wrap", 32'hFFFF_FFFC ^ TAG, 32'h0000_0000, 1'b1);
    chk("wrap_fcnt", Flush_Count, PERF ? 32'd5 : 32'd0);

    // Asynchronous reset in the middle of a stall
    PCoff = 1'b1; IFID_writeOff = 1'b1;
    tick();
    chk("pre_rst_state", {30'd0, Fetch_State}, 32'd2);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset("arst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
